baud_tick_gen_frac: RTL and testbench

Fractional (phase-accumulator) baud tick generator with a runtime-programmable rate, an oversample tick, a derived bit tick and a phase restart for receiver start-bit alignment. It replaces the integer-divider tick generator in the UART TX/RX paths. With integer division, rounding error accumulates at high baud rates. This block keeps the long-term tick rate accurate to 2^-AccWidth of the clock rate and lets software change baud without re-synthesis.

---
 rtl/baud_tick_gen_frac.sv | 109 ++++++++++
 tb/tb_baud_tick_gen_frac.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen_frac.sv
// baud_tick_gen_frac: fractional (phase-accumulator) baud tick generator.
// The accumulator adds inc_q every cycle. Its carry out is the oversample
// tick (os_tick). Every Oversampling os_ticks a bit_tick is produced.
// Optional feature macro: BAUDGEN_HALF_RESTART_EN. When it is defined,
// restart preloads os_phase to Oversampling/2 so that the first bit_tick
// after restart lands in the middle of the bit (RX centre alignment).
module baud_tick_gen_frac #(
    parameter int AccWidth     = 16,
    parameter int Oversampling = 16,
    parameter int DefaultInc   = 2416
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                restart,
    input  logic                inc_load,
    input  logic [AccWidth-1:0] baud_inc,
    output logic                os_tick,
    output logic                bit_tick,
    output logic [((Oversampling > 1) ? $clog2(Oversampling) : 1)-1:0] os_phase,
    output logic [AccWidth-1:0] inc_q
);

    localparam int PhW = (Oversampling > 1) ? $clog2(Oversampling) : 1;

    localparam logic [AccWidth-1:0] DEF_INC = AccWidth'(DefaultInc);
    localparam logic [PhW-1:0]      PH_LAST = PhW'(Oversampling - 1);

`ifdef BAUDGEN_HALF_RESTART_EN
    // Restart lands half a bit into the oversample cycle (bit-centre sampling).
    localparam logic [PhW-1:0] PH_RESTART = PhW'(Oversampling / 2);
`else
    localparam logic [PhW-1:0] PH_RESTART = {PhW{1'b0}};
`endif

    logic [AccWidth-1:0] acc_q;
    logic [AccWidth-1:0] acc_d;
    logic [AccWidth-1:0] inc_d;
    logic [PhW-1:0]      os_phase_q;
    logic [PhW-1:0]      os_phase_d;
    logic                os_tick_q;
    logic                os_tick_d;
    logic                bit_tick_q;
    logic                bit_tick_d;
    logic [AccWidth:0]   sum_s;

    // Next-state: increment capture, then disable > restart > accumulate.
    always_comb begin
        sum_s      = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d      = acc_q;
        os_phase_d = os_phase_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;

        // The increment is loadable in every state; acc is left untouched
        // so a rate change causes no phase jump.
        if (inc_load) begin
            inc_d = baud_inc;
        end else begin
            inc_d = inc_q;
        end

        if (!enable) begin
            acc_d      = {AccWidth{1'b0}};
            os_phase_d = {PhW{1'b0}};
        end else if (restart) begin
            acc_d      = {AccWidth{1'b0}};
            os_phase_d = PH_RESTART;
        end else begin
            acc_d     = sum_s[AccWidth-1:0];
            os_tick_d = sum_s[AccWidth];
            if (sum_s[AccWidth]) begin
                // Wrap at the last oversample index; the wrap is the bit tick.
                // With Oversampling == 1 this wraps every carry, so bit_tick
                // follows os_tick and the phase stays 0.
                if (os_phase_q == PH_LAST) begin
                    os_phase_d = {PhW{1'b0}};
                    bit_tick_d = 1'b1;
                end else begin
                    os_phase_d = os_phase_q + {{(PhW-1){1'b0}}, 1'b1};
                end
            end else begin
                os_phase_d = os_phase_q;
            end
        end
    end

    // State and registered tick outputs; async reset restores the default rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= {AccWidth{1'b0}};
            inc_q      <= DEF_INC;
            os_phase_q <= {PhW{1'b0}};
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            os_phase_q <= os_phase_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign os_phase = os_phase_q;

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Self-checking bench for baud_tick_gen_frac (AccWidth 16, Oversampling 16).
// Table vectors go through an expected-value queue; multi-cycle corners are
// hand-written sequences.
module tb_baud_tick_gen_frac;

    localparam int AW  = 16;
    localparam int OS  = 16;
    localparam int DEF = 2416;
`ifdef BAUDGEN_HALF_RESTART_EN
    localparam int RP = OS / 2;
`else
    localparam int RP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          restart = 1'b0;
    logic          inc_load = 1'b0;
    logic [AW-1:0] baud_inc = 16'd0;
    logic          os_tick;
    logic          bit_tick;
    logic [3:0]    os_phase;
    logic [AW-1:0] inc_q;

    int tests = 0;
    int fails = 0;

    baud_tick_gen_frac #(.AccWidth(AW), .Oversampling(OS), .DefaultInc(DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .restart  (restart),
        .inc_load (inc_load),
        .baud_inc (baud_inc),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .os_phase (os_phase),
        .inc_q    (inc_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en; logic rs; logic ld; logic [AW-1:0] bi;
        logic eos; logic ebit; int eph; int einc;
    } vec_t;

    typedef struct {
        logic os; logic bt; int ph; int inc;
    } exp_t;

    vec_t tbl[18];
    exp_t sbq[$];

    function automatic vec_t mk(logic en, logic rs, logic ld, int bi,
                                logic eos, logic ebit, int eph, int einc);
        vec_t v;
        v.en = en; v.rs = rs; v.ld = ld; v.bi = AW'(bi);
        v.eos = eos; v.ebit = ebit; v.eph = eph % OS; v.einc = einc;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_os;
        int n_bit;
        int gap_bad;
        int last;
        int lo;
        int hi;
        int exp_cnt;
        int c;
        bit found;
        exp_t e;

        // ---------------- reset state ----------------
        enable = 1'b1;
        #23;
        chk("rst_os_tick", os_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_os_phase", os_phase, 0);
        chk("rst_inc_q", inc_q, DEF);

        // ---------------- default rate, 50000 cycles ----------------
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_os = 0; n_bit = 0;
        for (int k = 0; k < 50000; k++) begin
            step();
            n_os  += int'(os_tick);
            n_bit += int'(bit_tick);
        end
        chk_rng("default_os_count", n_os, 1843, 1844);
        chk_rng("default_bit_count", n_bit, (n_os / 16) - 1, (n_os / 16) + 1);

        // ---------------- table vectors ----------------
        tbl[0]  = mk(1, 1, 1, 16384, 0, 0, RP,     16384);
        tbl[1]  = mk(1, 0, 0, 0,     0, 0, RP,     16384);
        tbl[2]  = mk(1, 0, 0, 0,     0, 0, RP,     16384);
        tbl[3]  = mk(1, 0, 0, 0,     0, 0, RP,     16384);
        tbl[4]  = mk(1, 0, 0, 0,     1, 0, RP + 1, 16384);
        tbl[5]  = mk(1, 0, 0, 0,     0, 0, RP + 1, 16384);
        tbl[6]  = mk(1, 0, 0, 0,     0, 0, RP + 1, 16384);
        tbl[7]  = mk(1, 0, 0, 0,     0, 0, RP + 1, 16384);
        tbl[8]  = mk(1, 0, 0, 0,     1, 0, RP + 2, 16384);
        tbl[9]  = mk(0, 0, 0, 0,     0, 0, 0,      16384);
        tbl[10] = mk(1, 0, 1, 32768, 0, 0, 0,      32768);
        tbl[11] = mk(1, 0, 0, 0,     0, 0, 0,      32768);
        tbl[12] = mk(1, 0, 0, 0,     1, 0, 1,      32768);
        tbl[13] = mk(1, 0, 0, 0,     0, 0, 1,      32768);
        tbl[14] = mk(1, 0, 0, 0,     1, 0, 2,      32768);
        tbl[15] = mk(1, 1, 1, 0,     0, 0, RP,     0);
        tbl[16] = mk(1, 0, 0, 0,     0, 0, RP,     0);
        tbl[17] = mk(1, 0, 0, 0,     0, 0, RP,     0);

        for (int i = 0; i < 18; i++) begin
            enable   = tbl[i].en;
            restart  = tbl[i].rs;
            inc_load = tbl[i].ld;
            baud_inc = tbl[i].bi;
            e.os = tbl[i].eos; e.bt = tbl[i].ebit; e.ph = tbl[i].eph; e.inc = tbl[i].einc;
            sbq.push_back(e);
            step();
            e = sbq.pop_front();
            chk($sformatf("vec%0d_os_tick", i), os_tick, e.os);
            chk($sformatf("vec%0d_bit_tick", i), bit_tick, e.bt);
            chk($sformatf("vec%0d_os_phase", i), os_phase, e.ph);
            chk($sformatf("vec%0d_inc_q", i), inc_q, e.inc);
        end
        enable = 1'b1; restart = 1'b0; inc_load = 1'b0;

        // ---------------- exact divide + restart at os_phase 9 ----------------
        restart = 1'b1; inc_load = 1'b1; baud_inc = 16'd16384;
        step();
        restart = 1'b0; inc_load = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (os_phase == 4'd9) found = 1'b1;
        end
        chk("reach_phase9", found, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_phase", os_phase, RP);
        chk("restart_os_tick", os_tick, 0);
        for (int k = 1; k <= 160; k++) begin
            step();
            c = k / 4;
            chk($sformatf("div_os_tick@%0d", k), os_tick, (k % 4) == 0);
            chk($sformatf("div_os_phase@%0d", k), os_phase, (RP + c) % OS);
            chk($sformatf("div_bit_tick@%0d", k), bit_tick,
                ((k % 4) == 0) && (((RP + c) % OS) == 0));
        end

        // ---------------- live load of 0 stops ticks ----------------
        restart = 1'b1; inc_load = 1'b1; baud_inc = 16'd32768;
        step();
        restart = 1'b0; inc_load = 1'b0;
        n_os = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            n_os += int'(os_tick);
        end
        chk("half_rate_count", n_os, 4);
        inc_load = 1'b1; baud_inc = 16'd0;
        step();
        inc_load = 1'b0;
        chk("zero_inc_q", inc_q, 0);
        n_os = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_os += int'(os_tick) + int'(bit_tick);
        end
        chk("zero_inc_no_ticks", n_os, 0);

        // ---------------- fractional rate ----------------
        restart = 1'b1; inc_load = 1'b1; baud_inc = 16'd10923;
        step();
        restart = 1'b0; inc_load = 1'b0;
        lo = 65536 / 10923;
        hi = ((65536 % 10923) != 0) ? lo + 1 : lo;
        exp_cnt = int'((longint'(16384) * 10923) / 65536);
        n_os = 0; gap_bad = 0; last = 0;
        for (int k = 1; k <= 16384; k++) begin
            step();
            if (os_tick) begin
                if (n_os > 0 && ((k - last) < lo || (k - last) > hi)) gap_bad++;
                n_os++;
                last = k;
            end
        end
        chk("frac_os_count", n_os, exp_cnt);
        chk("frac_gap_violations", gap_bad, 0);

        // ---------------- async reset mid-stream ----------------
        restart = 1'b1; inc_load = 1'b1; baud_inc = 16'd32768;
        step();
        restart = 1'b0; inc_load = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (os_tick) found = 1'b1;
        end
        chk("async_pre_tick_seen", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_os_tick", os_tick, 0);
        chk("async_bit_tick", bit_tick, 0);
        chk("async_os_phase", os_phase, 0);
        chk("async_inc_q", inc_q, DEF);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
